pcl_3w_burst_master: RTL



---
 rtl/pcl_3w_burst_master.sv | 245 ++++++++++++++++++++++++
 1 files changed

// File: rtl/pcl_3w_burst_master.sv
// Host-protocol decoder for multi-channel 3-wire access: framed read/write bursts
// with address auto-increment, per-wait timeouts and OK/ERR status replies.
module pcl_3w_burst_master #(
  parameter int ADDR_BITS = 9,
  parameter int DATA_BITS = 16,
  parameter int CHANNELS  = 4,
  parameter int TIMEOUT   = 1024
) (
  input  logic                          in_clk,
  input  logic                          in_rst,
  input  logic [7:0]                    in_rx_data,
  input  logic                          in_rx_done,
  output logic                          out_rx_trig,
  output logic [7:0]                    out_tx_data,
  output logic                          out_tx_trig,
  input  logic                          in_tx_done,
  output logic                          out_tw_start,
  output logic [CHANNELS-1:0]           out_tw_sel,
  output logic                          out_tw_mode_wr,
  output logic [ADDR_BITS-1:0]          out_tw_addr,
  output logic [DATA_BITS-1:0]          out_tw_wr_data,
  input  logic [CHANNELS*DATA_BITS-1:0] in_tw_rd_data,
  input  logic [CHANNELS-1:0]           in_tw_busy,
  output logic [1:0]                    out_err
);
  localparam int ADDR_BYTES = (ADDR_BITS + 7) / 8;
  localparam int DATA_BYTES = (DATA_BITS + 7) / 8;
  localparam int MAX_BYTES  = (ADDR_BYTES > DATA_BYTES) ? ADDR_BYTES : DATA_BYTES;
  localparam int BC_W       = $clog2(MAX_BYTES) + 1;
  localparam int TM_W       = $clog2(TIMEOUT) + 1;
  localparam int RD_W       = DATA_BYTES * 8;
  localparam logic [7:0] ST_OK  = 8'h02;
  localparam logic [7:0] ST_ERR = 8'hEE;

  typedef enum logic [3:0] {
    WAIT_CMD, WAIT_CNT, WAIT_ADDR, WAIT_WRDATA, TW_START,
    TW_WAIT_BUSY, TW_WAIT_DONE, TX_DATA, TX_STATUS
  } state_t;

  state_t                state_q, state_nxt;
  logic [CHANNELS-1:0]   sel_q, sel_nxt;
  logic                  wr_q, wr_nxt;
  logic [7:0]            cnt_q, cnt_nxt;
  logic [ADDR_BITS-1:0]  addr_q, addr_nxt;
  logic [DATA_BITS-1:0]  wdata_q, wdata_nxt;
  logic [RD_W-1:0]       rdata_q, rdata_nxt;
  logic [BC_W-1:0]       bcnt_q, bcnt_nxt;
  logic [TM_W-1:0]       tmr_q, tmr_nxt;
  logic [1:0]            err_q, err_nxt;
  logic [7:0]            tx_data_q, tx_data_nxt;
  logic                  rx_trig_q, rx_trig_nxt;
  logic                  tx_trig_q, tx_trig_nxt;
  logic                  start_q, start_nxt;
  logic [DATA_BITS-1:0]  rd_sel;
  logic [RD_W-1:0]       rd_pad;
  logic                  busy_sel;

  always_comb begin
    rd_sel = '0;
    for (int k = 0; k < CHANNELS; k++)
      if (sel_q[k]) rd_sel = rd_sel | in_tw_rd_data[k*DATA_BITS +: DATA_BITS];
  end
  assign rd_pad   = RD_W'(rd_sel);
  assign busy_sel = |(in_tw_busy & sel_q);

  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst) begin
      state_q   <= WAIT_CMD;
      sel_q     <= '0;
      wr_q      <= 1'b0;
      cnt_q     <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      bcnt_q    <= '0;
      tmr_q     <= '0;
      err_q     <= '0;
      tx_data_q <= '0;
      rx_trig_q <= 1'b0;
      tx_trig_q <= 1'b0;
      start_q   <= 1'b0;
    end else begin
      state_q   <= state_nxt;
      sel_q     <= sel_nxt;
      wr_q      <= wr_nxt;
      cnt_q     <= cnt_nxt;
      addr_q    <= addr_nxt;
      wdata_q   <= wdata_nxt;
      rdata_q   <= rdata_nxt;
      bcnt_q    <= bcnt_nxt;
      tmr_q     <= tmr_nxt;
      err_q     <= err_nxt;
      tx_data_q <= tx_data_nxt;
      rx_trig_q <= rx_trig_nxt;
      tx_trig_q <= tx_trig_nxt;
      start_q   <= start_nxt;
    end
  end

  always_comb begin
    state_nxt   = state_q;
    sel_nxt     = sel_q;
    wr_nxt      = wr_q;
    cnt_nxt     = cnt_q;
    addr_nxt    = addr_q;
    wdata_nxt   = wdata_q;
    rdata_nxt   = rdata_q;
    bcnt_nxt    = bcnt_q;
    tmr_nxt     = tmr_q;
    err_nxt     = err_q;
    tx_data_nxt = tx_data_q;
    rx_trig_nxt = 1'b0;
    tx_trig_nxt = 1'b0;
    start_nxt   = 1'b0;
    case (state_q)
      WAIT_CMD: if (in_rx_done) begin
        if (!in_rx_data[7] && ({1'b0, in_rx_data[5:0]} < 7'(CHANNELS))) begin
          sel_nxt     = CHANNELS'(1) << in_rx_data[5:0];
          wr_nxt      = in_rx_data[6];
          err_nxt     = 2'b00;
          rx_trig_nxt = 1'b1;
          state_nxt   = WAIT_CNT;
        end else begin
          err_nxt[0]  = 1'b1;
          tx_data_nxt = ST_ERR;
          tx_trig_nxt = 1'b1;
          state_nxt   = TX_STATUS;
        end
      end
      WAIT_CNT: if (in_rx_done) begin
        if (in_rx_data == 8'd0) begin
          err_nxt[0]  = 1'b1;
          tx_data_nxt = ST_ERR;
          tx_trig_nxt = 1'b1;
          state_nxt   = TX_STATUS;
        end else begin
          cnt_nxt     = in_rx_data;
          bcnt_nxt    = BC_W'(ADDR_BYTES - 1);
          rx_trig_nxt = 1'b1;
          state_nxt   = WAIT_ADDR;
        end
      end
      // Shifting MSB-first through a truncating cast drops bits above ADDR_BITS.
      WAIT_ADDR: if (in_rx_done) begin
        addr_nxt = ADDR_BITS'({addr_q, in_rx_data});
        if (bcnt_q != '0) begin
          bcnt_nxt    = bcnt_q - 1'b1;
          rx_trig_nxt = 1'b1;
        end else if (wr_q) begin
          bcnt_nxt    = BC_W'(DATA_BYTES - 1);
          rx_trig_nxt = 1'b1;
          state_nxt   = WAIT_WRDATA;
        end else begin
          state_nxt   = TW_START;
        end
      end
      WAIT_WRDATA: if (in_rx_done) begin
        wdata_nxt = DATA_BITS'({wdata_q, in_rx_data});
        if (bcnt_q != '0) begin
          bcnt_nxt    = bcnt_q - 1'b1;
          rx_trig_nxt = 1'b1;
        end else begin
          state_nxt   = TW_START;
        end
      end
      TW_START: begin
        start_nxt = 1'b1;
        tmr_nxt   = TM_W'(TIMEOUT - 1);
        state_nxt = TW_WAIT_BUSY;
      end
      TW_WAIT_BUSY: begin
        if (busy_sel) begin
          tmr_nxt   = TM_W'(TIMEOUT - 1);
          state_nxt = TW_WAIT_DONE;
        end else if (tmr_q == '0) begin
          err_nxt[1]  = 1'b1;
          tx_data_nxt = ST_ERR;
          tx_trig_nxt = 1'b1;
          state_nxt   = TX_STATUS;
        end else begin
          tmr_nxt = tmr_q - 1'b1;
        end
      end
      TW_WAIT_DONE: begin
        if (!busy_sel) begin
          cnt_nxt = cnt_q - 8'd1;
          if (!wr_q) begin
            tx_data_nxt = rd_pad[RD_W-1 -: 8];
            rdata_nxt   = rd_pad << 8;
            bcnt_nxt    = BC_W'(DATA_BYTES - 1);
            tx_trig_nxt = 1'b1;
            state_nxt   = TX_DATA;
          end else if (cnt_q != 8'd1) begin
            addr_nxt    = addr_q + ADDR_BITS'(1);
            bcnt_nxt    = BC_W'(DATA_BYTES - 1);
            rx_trig_nxt = 1'b1;
            state_nxt   = WAIT_WRDATA;
          end else begin
            tx_data_nxt = ST_OK;
            tx_trig_nxt = 1'b1;
            state_nxt   = TX_STATUS;
          end
        end else if (tmr_q == '0) begin
          err_nxt[1]  = 1'b1;
          tx_data_nxt = ST_ERR;
          tx_trig_nxt = 1'b1;
          state_nxt   = TX_STATUS;
        end else begin
          tmr_nxt = tmr_q - 1'b1;
        end
      end
      TX_DATA: if (in_tx_done) begin
        if (bcnt_q != '0) begin
          tx_data_nxt = rdata_q[RD_W-1 -: 8];
          rdata_nxt   = rdata_q << 8;
          bcnt_nxt    = bcnt_q - 1'b1;
          tx_trig_nxt = 1'b1;
        end else if (cnt_q != 8'd0) begin
          addr_nxt  = addr_q + ADDR_BITS'(1);
          state_nxt = TW_START;
        end else begin
          tx_data_nxt = ST_OK;
          tx_trig_nxt = 1'b1;
          state_nxt   = TX_STATUS;
        end
      end
      TX_STATUS: if (in_tx_done) begin
        rx_trig_nxt = 1'b1;
        sel_nxt     = '0;
        state_nxt   = WAIT_CMD;
      end
      default: state_nxt = WAIT_CMD;
    endcase
  end

  assign out_rx_trig    = rx_trig_q;
  assign out_tx_data    = tx_data_q;
  assign out_tx_trig    = tx_trig_q;
  assign out_tw_start   = start_q;
  assign out_tw_sel     = sel_q;
  assign out_tw_mode_wr = wr_q;
  assign out_tw_addr    = addr_q;
  assign out_tw_wr_data = wdata_q;
  assign out_err        = err_q;
endmodule
